uart_tx_frame: RTL and testbench

UART transmitter that serializes one DATA_WIDTH-bit word per request onto a single idle-high line. The frame is a start bit, data bits sent LSB first, an optional even-parity bit, and one stop bit. It is the transmit-side counterpart of the design's UART receive path, and its framing and default baud divisor match that path. It sits between a word-oriented producer, which uses a start/busy/done handshake, and the external TX pin.

---
 rtl/uart_tx_frame.sv | 132 +++++++++++++
 tb/tb_uart_tx_frame.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Sends one DATA_WIDTH-bit word per accepted
// request as start bit, data bits LSB first, optional even-parity bit and one
// stop bit on an idle-high line. Every bit lasts exactly BAUD_DIV clocks.
// Handshake: start is accepted only while busy=0. done pulses for one cycle
// after the stop bit, and that same cycle can accept the next request.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 16,
    parameter int BAUD_DIV   = 434,
    parameter int PARITY_EN  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  TX
);

    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q,  state_d;
    logic [BAUD_W-1:0]     baud_q,   baud_d;
    logic [BIT_W-1:0]      bit_q,    bit_d;
    logic [DATA_WIDTH-1:0] hold_q,   hold_d;
    logic                  parity_q, parity_d;
    logic                  tx_q,     tx_d;
    logic                  done_q,   done_d;
    logic                  bit_end;

    // A bit period ends when the baud counter reaches its last count.
    assign bit_end = (baud_q == BAUD_LAST);

    // Next-state, counter and datapath update; TX is decoded from the next
    // state so the registered line changes on the same edge as the state.
    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        hold_d   = hold_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (start) begin
                    state_d  = S_START;
                    hold_d   = data_in;
                    parity_d = ^data_in;
                    bit_d    = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // The holding register shifts right so TX always takes bit 0.
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        hold_d = hold_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = hold_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and datapath registers with synchronous reset to an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            hold_q   <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            hold_q   <= hold_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign TX   = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame with BAUD_DIV=4 and
// DATA_WIDTH=16; dut0 runs without parity, dut1 with even parity.
module tb_uart_tx_frame;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [15:0] data0,  data1;
    logic        busy0, done0, tx0;
    logic        busy1, done1, tx1;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_frame #(.DATA_WIDTH(16), .BAUD_DIV(4), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .data_in(data0),
        .busy(busy0), .done(done0), .TX(tx0)
    );

    uart_tx_frame #(.DATA_WIDTH(16), .BAUD_DIV(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(data1),
        .busy(busy1), .done(done1), .TX(tx1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input int sel, input logic s, input logic [15:0] d);
        if (sel == 0) begin
            start0 = s;
            data0  = d;
        end else begin
            start1 = s;
            data1  = d;
        end
    endtask

    // Expected {TX, busy, done} in cycle c of a frame (BAUD_DIV=4).
    function automatic logic [2:0] model(input logic [15:0] d, input int pe, input int c);
        int n;
        int idx;
        n = 18 + pe;
        if (c < 1 || c > n * 4 + 1) return 3'b100;
        if (c == n * 4 + 1) return 3'b101;
        idx = (c - 1) / 4;
        if (idx == 0) return 3'b010;
        if (idx <= 16) return {d[idx-1], 2'b10};
        if (idx == 17 && pe != 0) return {^d, 2'b10};
        return 3'b110;
    endfunction

    // Called just after a negedge. Unless preloaded, raises start so the
    // next posedge is cycle 0. inj_kind: 0 none, 1 start with inj_data,
    // 2 reset, applied so that it is sampled on edge inj_cyc.
    task automatic frame(input string name, input int sel, input logic [15:0] d,
                         input bit preloaded, input int total, input int inj_cyc,
                         input int inj_kind, input logic [15:0] inj_data);
        logic [2:0] e;
        logic [2:0] got;
        bit aborted;
        aborted = 1'b0;
        if (!preloaded) drive(sel, 1'b1, d);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            e   = aborted ? 3'b100 : model(d, sel, c);
            got = (sel != 0) ? {tx1, busy1, done1} : {tx0, busy0, done0};
            check($sformatf("%s tx c%0d", name, c),   32'(got[2]), 32'(e[2]));
            check($sformatf("%s busy c%0d", name, c), 32'(got[1]), 32'(e[1]));
            check($sformatf("%s done c%0d", name, c), 32'(got[0]), 32'(e[0]));
            drive(sel, 1'b0, 16'h0000);
            rst = 1'b0;
            if (c == inj_cyc) begin
                if (inj_kind == 1) drive(sel, 1'b1, inj_data);
                if (inj_kind == 2) begin
                    rst     = 1'b1;
                    aborted = 1'b1;
                end
            end
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check($sformatf("%s tx0 %0d", name, c),   32'(tx0),   32'd1);
            check($sformatf("%s busy0 %0d", name, c), 32'(busy0), 32'd0);
            check($sformatf("%s done0 %0d", name, c), 32'(done0), 32'd0);
            check($sformatf("%s tx1 %0d", name, c),   32'(tx1),   32'd1);
            check($sformatf("%s busy1 %0d", name, c), 32'(busy1), 32'd0);
            check($sformatf("%s done1 %0d", name, c), 32'(done1), 32'd0);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        data0  = 16'h0000;
        data1  = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst tx",   32'(tx0),   32'd1);
        check("rst busy", 32'(busy0), 32'd0);
        check("rst done", 32'(done0), 32'd0);
        rst = 1'b0;
        check_idle("idle", 20);

        // start together with reset must be ignored
        rst    = 1'b1;
        start0 = 1'b1;
        data0  = 16'h1234;
        start1 = 1'b1;
        data1  = 16'h1234;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 16'h0000);
        drive(1, 1'b0, 16'h0000);
        check_idle("start_in_rst", 6);

        // basic frame, no parity: bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
        frame("basic", 0, 16'hA5C3, 1'b0, 73 + 5, 0, 0, 16'h0000);

        // parity frames: 16'h0001 -> parity 1; 16'hC003 -> parity 0
        frame("par1", 1, 16'h0001, 1'b0, 77 + 3, 0, 0, 16'h0000);
        frame("par0", 1, 16'hC003, 1'b0, 77 + 3, 0, 0, 16'h0000);

        // start while busy is ignored; no second frame afterwards
        frame("busyrej", 0, 16'h00FF, 1'b0, 73 + 20, 10, 1, 16'h1234);

        // back-to-back: next start raised during the done cycle
        frame("b2b_a", 0, 16'h3C5A, 1'b0, 73, 73, 1, 16'hFFFF);
        frame("b2b_b", 0, 16'hFFFF, 1'b1, 73 + 3, 0, 0, 16'h0000);
        frame("b2b_p0", 1, 16'h8001, 1'b0, 77, 77, 1, 16'h7FFF);
        frame("b2b_p1", 1, 16'h7FFF, 1'b1, 77 + 3, 0, 0, 16'h0000);

        // mid-frame reset at cycle 30, then a fresh complete frame
        frame("midrst", 0, 16'h5A3C, 1'b0, 60, 30, 2, 16'h0000);
        frame("after_rst", 0, 16'h5A3C, 1'b0, 73 + 3, 0, 0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
